// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings and the
// elaboration-time parameter legality check.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 32'sd0;
    localparam int FIFO_MODE_FWFT = 32'sd1;

    // Legal when DEPTH is a power of two >= 4, margins lie in 0..DEPTH-1 and the mode is known.
    function automatic bit fifo_params_ok(input int depth, input int prog_full,
                                          input int prog_empty, input int fwft);
        return (depth >= 32'sd4)
            && ((depth & (depth - 32'sd1)) == 32'sd0)
            && (prog_full >= 32'sd0) && (prog_full < depth)
            && (prog_empty >= 32'sd0) && (prog_empty < depth)
            && ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port storage for the single-clock FIFO: synchronous write,
// synchronous read with read enable, contents never reset.
module fifo_sc_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; rdata holds its value while re is low, which the FWFT stage relies on.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/fifo_singleclock_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// level, programmable almost-full/empty flags and overflow/underflow pulses.
module fifo_singleclock_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int PROG_FULL  = 0,
    parameter int PROG_EMPTY = 0,
    parameter int FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     prog_full,
    output logic                     empty,
    output logic                     prog_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] DEPTH_L   = PW'(DEPTH);
    localparam logic [PW-1:0] PF_THRESH = PW'(DEPTH - PROG_FULL);
    localparam logic [PW-1:0] PE_THRESH = PW'(PROG_EMPTY);

    if (!fifo_params_ok(DEPTH, PROG_FULL, PROG_EMPTY, FWFT)) begin : g_bad_params
        $fatal(1, "fifo_singleclock_fwft: illegal parameter set");
    end

    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, level_r;
    logic [PW-1:0]    wr_ptr_next_s, rd_ptr_next_s, level_next_s;
    logic             out_valid_r, out_valid_next_s, dout_live_r;
    logic             full_r, empty_r, prog_full_r, prog_empty_r;
    logic             overflow_r, underflow_r;
    logic             full_next_s, empty_next_s;
    logic             wr_acc_s, rd_acc_s, ram_has_s, ram_re_s;
    logic [WIDTH-1:0] ram_q_s;

    fifo_sc_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (din),
        .re    (ram_re_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (ram_q_s)
    );

    // Accept decisions, pointer/level next-state and next flag values.
    always_comb begin
        wr_acc_s         = wr_en & ~full_r;
        rd_acc_s         = rd_en & ~empty_r;
        ram_has_s        = (wr_ptr_r != rd_ptr_r);
        ram_re_s         = 1'b0;
        out_valid_next_s = 1'b0;
        // In FWFT the RAM read register is the output stage: refill it when idle or popped.
        if (FWFT == FIFO_MODE_FWFT) begin
            ram_re_s = ram_has_s & (~out_valid_r | rd_acc_s);
            if (ram_re_s) begin
                out_valid_next_s = 1'b1;
            end else if (rd_acc_s) begin
                out_valid_next_s = 1'b0;
            end else begin
                out_valid_next_s = out_valid_r;
            end
        end else begin
            ram_re_s         = rd_acc_s;
            out_valid_next_s = 1'b0;
        end
        if (wr_acc_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (ram_re_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_next_s = level_r + PTR_ONE;
            2'b01:   level_next_s = level_r - PTR_ONE;
            default: level_next_s = level_r;
        endcase
        // FWFT counts the output register as storage, so fullness comes from the total level.
        if (FWFT == FIFO_MODE_FWFT) begin
            empty_next_s = ~out_valid_next_s;
            full_next_s  = (level_next_s == DEPTH_L);
        end else begin
            empty_next_s = (wr_ptr_next_s == rd_ptr_next_s);
            full_next_s  = (wr_ptr_next_s[PW-1] != rd_ptr_next_s[PW-1])
                        && (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            level_r      <= {PW{1'b0}};
            out_valid_r  <= 1'b0;
            dout_live_r  <= 1'b0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            prog_full_r  <= 1'b0;
            prog_empty_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            level_r      <= level_next_s;
            out_valid_r  <= out_valid_next_s;
            dout_live_r  <= dout_live_r | ram_re_s;
            full_r       <= full_next_s;
            empty_r      <= empty_next_s;
            prog_full_r  <= (level_next_s >= PF_THRESH);
            prog_empty_r <= (level_next_s <= PE_THRESH);
            overflow_r   <= wr_en & full_r;
            underflow_r  <= rd_en & empty_r;
        end
    end

    // The RAM read register is not reset; dout_live_r forces zero until it holds real data.
    assign dout       = ram_q_s & {WIDTH{dout_live_r}};
    assign full       = full_r;
    assign prog_full  = prog_full_r;
    assign empty      = empty_r;
    assign prog_empty = prog_empty_r;
    assign level      = level_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_fifo_singleclock_fwft.sv
// Randomised scoreboard bench running a standard-read and an FWFT instance
// side by side against a queue-based reference model.
module tb_fifo_singleclock_fwft;

    logic       clk, rst_n, wr_en, rd_en;
    logic [7:0] din;
    logic [7:0] dout0, dout1;
    logic [3:0] level0, level1;
    logic       full0, pfull0, empty0, pempty0, ovf0, unf0;
    logic       full1, pfull1, empty1, pempty1, ovf1, unf1;

    fifo_singleclock_fwft #(.WIDTH(8), .DEPTH(8), .PROG_FULL(2), .PROG_EMPTY(1), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout0),
        .full(full0), .prog_full(pfull0), .empty(empty0), .prog_empty(pempty0),
        .level(level0), .overflow(ovf0), .underflow(unf0));

    fifo_singleclock_fwft #(.WIDTH(8), .DEPTH(8), .PROG_FULL(2), .PROG_EMPTY(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout1),
        .full(full1), .prog_full(pfull1), .empty(empty1), .prog_empty(pempty1),
        .level(level1), .overflow(ovf1), .underflow(unf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per mode, a ring of stored words tagged with the edge that wrote them.
    logic [7:0] md [2][64];
    int         mt [2][64];
    int         mh [2];
    int         mc [2];
    bit         ovf_e [2];
    bit         unf_e [2];
    logic [7:0] last_rd;
    int         ecount;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] want0;
    int         vectors, miscompares;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    // A word becomes readable at the edge it is written (standard) or one edge later (FWFT).
    function automatic bit visible(input int m);
        if (mc[m] == 0) return 1'b0;
        return mt[m][mh[m]] <= ecount - m;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mh[m] = 0; mc[m] = 0; ovf_e[m] = 1'b0; unf_e[m] = 1'b0;
        end
        last_rd = 8'h00;
        ecount  = 0;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic check_one(input int m, input int lvl, input bit f, input bit pf, input bit e,
                             input bit pe, input bit ov, input bit un, input int d);
        string t;
        t = (m == 1) ? "fwft" : "std";
        chk({t, ".level"},      lvl, mc[m]);
        chk({t, ".full"},       f,   int'(mc[m] == 8));
        chk({t, ".prog_full"},  pf,  int'(mc[m] >= 6));
        chk({t, ".empty"},      e,   int'(!visible(m)));
        chk({t, ".prog_empty"}, pe,  int'(mc[m] <= 1));
        chk({t, ".overflow"},   ov,  int'(ovf_e[m]));
        chk({t, ".underflow"},  un,  int'(unf_e[m]));
        if (m == 0) chk({t, ".dout_hold"}, d, last_rd);
        else if (visible(1)) chk({t, ".dout_head"}, d, md[1][mh[1]]);
    endtask

    task automatic check_outputs();
        check_one(0, level0, full0, pfull0, empty0, pempty0, ovf0, unf0, dout0);
        check_one(1, level1, full1, pfull1, empty1, pempty1, ovf1, unf1, dout1);
    endtask

    // One clock cycle: check state, apply inputs, advance the model across the edge.
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit         wok, rok;
        logic [7:0] pd;
        int         idx;
        check_outputs();
        wr_en = w; rd_en = r; din = d;
        for (int m = 0; m < 2; m++) begin
            wok = w && (mc[m] < 8);
            rok = r && visible(m);
            ovf_e[m] = w && !wok;
            unf_e[m] = r && !rok;
            if (rok) begin
                pd = md[m][mh[m]];
                mh[m] = (mh[m] + 1) % 64;
                mc[m]--;
                if (m == 0) begin
                    exp0.push_back(pd);
                    last_rd = pd;
                end else begin
                    exp1.push_back(pd);
                end
            end
            if (wok) begin
                idx = (mh[m] + mc[m]) % 64;
                md[m][idx] = d;
                mt[m][idx] = ecount + 1;
                mc[m]++;
            end
        end
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("std.reset_empty",  empty0, 1);
        chk("std.reset_level",  level0, 0);
        chk("fwft.reset_empty", empty1, 1);
        chk("fwft.reset_level", level1, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // FWFT monitor: the head word is on dout at the moment a pop is accepted.
    always @(posedge clk) begin
        if (rst_n && rd_en && !empty1) begin
            if (exp1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL fwft.pop: got 0x%0h, want no read", dout1);
            end else begin
                chk("fwft.pop", dout1, exp1.pop_front());
            end
        end
    end

    // Standard monitor: the word appears on dout just after the accepting edge.
    always @(posedge clk) begin
        if (rst_n && rd_en && !empty0) begin
            if (exp0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL std.pop: got 0x%0h, want no read", dout0);
            end else begin
                want0 = exp0.pop_front();
                #1;
                chk("std.pop", dout0, want0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("fwft.reset_dout", dout1, 0);
        rst_n = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b0, 8'h00);
        // Drain, then one rejected read.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        // Single word latency into an empty FIFO.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        // Simultaneous push/pop at level 4, then at full.
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b0, 8'h00);
        // Reset at level 5, then a fresh word must come back first.
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        reset_pulse();
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        // Random traffic across pointer wrap.
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("std.unread_left",  exp0.size(), 0);
        chk("fwft.unread_left", exp1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
